adc_multislope_runup: RTL and testbench
=======================================

Name: adc_multislope_runup

Overview:
- Integrating ADC measurement controller at the far end of the acquisition sequencer's ADC handshake.
- The sequencer releases `adc_reset_ni` high to start a conversion and waits for `measure_valid_o`; this block answers that handshake.
- Per conversion it drives the signal and reference switch muxes through a multi-slope run-up over a programmed aperture, then a rundown to the comparator crossing.
- It holds the resulting counts, and asserts valid, until the sequencer re-asserts reset.

Parameters:
- RUNDOWN_MAX, 24'd1_000_000: rundown clock limit; reaching it ends rundown with overflow.
- SYNC_STAGES, 2: comparator synchroniser depth; legal range 2..3.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- adc_reset_ni  in  1  from sequencer. 0 = hold ADC in reset/abort; 1 = run conversion.
- p_clk_count_aper_i  in  24  aperture, in clocks.
- p_clk_count_fix_i  in  16  fixed (reference-off) phase length per run-up cycle; must be ≥1.
- p_clk_count_var_i  in  16  reference-on phase length per run-up cycle; must be ≥1.
- comparator_val_i  in  1  async integrator comparator. 1 = integrator positive.
- sigmux_o  out  1  1 = input signal connected to integrator.
- refmux_o  out  2  reference switch: 00 off, 01 positive ref, 10 negative ref, 11 integrator short.
- measure_valid_o  out  1  conversion complete; counts are stable.
- count_up_o  out  24  run-up cycles that used the positive reference.
- count_down_o  out  24  run-up cycles that used the negative reference.
- count_rundown_o  out  24  rundown clocks.
- rundown_dir_o  out  1  rundown reference used: 1 = negative, 0 = positive.
- overflow_o  out  1  rundown hit RUNDOWN_MAX.
- monitor_o  out  8  `{measure_valid_o, adc_reset_ni, comp_sync, sigmux_o, refmux_o[1:0], state[1:0]}`.

Behaviour:
- Reset: `reset_n`=0 forces state RESET on the next clk edge. Output values in RESET:
  - `sigmux_o`=0, `refmux_o`=11, `measure_valid_o`=0.
  - All count outputs = 0; `overflow_o`=0; `rundown_dir_o`=0.
- Comparator: pass it through SYNC_STAGES flops to form `comp_sync`. All decisions use `comp_sync`, so response lags the comparator by SYNC_STAGES clocks.
- Abort: `adc_reset_ni`=0 in any state other than RESET:
  - RESET is entered the next clock, with RESET outputs.
  - Internal counters clear; an in-progress conversion is discarded.
  - Abort has priority over every other transition in the same cycle.
- State RESET:
  - Outputs as at reset.
  - On `adc_reset_ni`=1:
    - Latch the aper, fix and var parameters.
    - Load the aperture down-counter.
    - Clear the internal up/down/rundown counters.
    - Go to VAR.
  - Parameter changes after this latch have no effect until the next conversion.
- State VAR (start of a run-up cycle):
  - On entry `sigmux_o`=1.
  - `refmux_o` = 10 if `comp_sync`=1, else 01, sampled on the entry clock.
  - The matching up or down counter is incremented by 1.
  - Hold for exactly var clocks, then go to FIX.
- State FIX:
  - `refmux_o`=00 for exactly fix clocks.
  - At the end of the phase: if the aperture counter has reached 0, go to RUNDOWN; else go to VAR.
- Aperture counter:
  - Decrements every clock in VAR/FIX and saturates at 0.
  - Run-up cycles = ceil(aper/(fix+var)), minimum 1 (aper=0 gives 1 cycle).
  - Only whole cycles are run.
- State RUNDOWN:
  - `sigmux_o`=0.
  - `rundown_dir_o` = `comp_sync` at entry; `refmux_o` = 10 if dir=1, else 01.
  - The rundown counter increments every clock in this state.
  - Leave when `comp_sync` != dir; the exit clock is not counted.
  - If the counter reaches RUNDOWN_MAX: set `overflow_o`=1 and leave.
  - Go to DONE.
- State DONE:
  - `refmux_o`=00 and `sigmux_o`=0.
  - Count outputs are registered from the internal counters on the entry clock, and `measure_valid_o`=1 from that same clock.
  - Hold until `adc_reset_ni`=0, then go to RESET next clock.
- Count outputs change only on DONE entry or in RESET; they never toggle mid-conversion.
- Counter widths: up/down counters saturate at 24'hFFFFFF.

Test Plan:
- `reset_n`=0 for 3 clk with `adc_reset_ni`=1 → `refmux_o`=11, `sigmux_o`=0, `measure_valid_o`=0, all counts 0. Release → VAR begins within 1 clk.
- aper=100, fix=5, var=5, comparator held 1; comparator driven 0 at 30 clk after RUNDOWN entry:
  - Expect `count_down_o`=10, `count_up_o`=0.
  - Expect `rundown_dir_o`=1, `refmux_o`=10 during rundown.
  - Expect `count_rundown_o`=30+SYNC_STAGES, valid=1, `overflow_o`=0.
- aper=40, fix=2, var=2, comparator toggled so that every VAR-entry sample alternates → `count_up_o`=5, `count_down_o`=5; `refmux_o` alternates 01/10 per cycle.
- `adc_reset_ni` dropped mid-VAR in cycle 3:
  - Next clk: `refmux_o`=11, `sigmux_o`=0, valid 0, counts 0.
  - Re-release with aper=0: exactly 1 run-up cycle, counts sum = 1.
- RUNDOWN_MAX=1000, comparator never crosses → `overflow_o`=1, `count_rundown_o`=1000, valid=1; `adc_reset_ni`=0 clears all.
- valid held 50 clk in DONE while comparator and parameter inputs toggle → counts and `refmux_o`=00 unchanged.

Source files
------------

// File: rtl/adc_multislope_runup.sv
// Multi-slope integrating ADC measurement controller: run-up over a programmed aperture,
// rundown to the comparator crossing, then hold counts with valid until re-armed.
module adc_multislope_runup #(
  parameter logic [23:0] RUNDOWN_MAX = 24'd1_000_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        adc_reset_ni,
  input  logic [23:0] p_clk_count_aper_i,
  input  logic [15:0] p_clk_count_fix_i,
  input  logic [15:0] p_clk_count_var_i,
  input  logic        comparator_val_i,
  output logic        sigmux_o,
  output logic [1:0]  refmux_o,
  output logic        measure_valid_o,
  output logic [23:0] count_up_o,
  output logic [23:0] count_down_o,
  output logic [23:0] count_rundown_o,
  output logic        rundown_dir_o,
  output logic        overflow_o,
  output logic [7:0]  monitor_o
);

  typedef enum logic [2:0] {
    StReset   = 3'd0,
    StVar     = 3'd1,
    StFix     = 3'd2,
    StRundown = 3'd3,
    StDone    = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] comp_sync_q;
  logic                   comp_sync;

  logic [15:0] fix_q, fix_d, var_q, var_d;
  logic [23:0] aper_cnt_q, aper_cnt_d, aper_dec;
  logic [15:0] phase_q, phase_d;
  logic [23:0] up_q, up_d, down_q, down_d, rundown_q, rundown_d;
  logic        dir_q, dir_d, ovf_q, ovf_d;
  logic        sigmux_q, sigmux_d, valid_q, valid_d;
  logic [1:0]  refmux_q, refmux_d, ref_sel;
  logic [23:0] out_up_q, out_up_d, out_down_q, out_down_d, out_rd_q, out_rd_d;
  logic        enter_var, finish;
  logic [15:0] var_len;

  function automatic logic [23:0] sat_inc(input logic [23:0] v);
    return (v == 24'hFFFFFF) ? v : v + 24'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      comp_sync_q <= '0;
    end else begin
      comp_sync_q <= {comp_sync_q[SYNC_STAGES-2:0], comparator_val_i};
    end
  end

  assign comp_sync = comp_sync_q[SYNC_STAGES-1];
  assign aper_dec  = (aper_cnt_q == 24'd0) ? 24'd0 : aper_cnt_q - 24'd1;
  // Integrator positive pulls it back with the negative reference.
  assign ref_sel   = comp_sync ? 2'b10 : 2'b01;

  always_comb begin
    state_d    = state_q;
    fix_d      = fix_q;
    var_d      = var_q;
    aper_cnt_d = aper_cnt_q;
    phase_d    = phase_q;
    up_d       = up_q;
    down_d     = down_q;
    rundown_d  = rundown_q;
    dir_d      = dir_q;
    ovf_d      = ovf_q;
    sigmux_d   = sigmux_q;
    refmux_d   = refmux_q;
    valid_d    = valid_q;
    out_up_d   = out_up_q;
    out_down_d = out_down_q;
    out_rd_d   = out_rd_q;
    enter_var  = 1'b0;
    finish     = 1'b0;
    var_len    = var_q;

    if (!adc_reset_ni) begin
      state_d    = StReset;
      aper_cnt_d = '0;
      phase_d    = '0;
      up_d       = '0;
      down_d     = '0;
      rundown_d  = '0;
      dir_d      = 1'b0;
      ovf_d      = 1'b0;
      sigmux_d   = 1'b0;
      refmux_d   = 2'b11;
      valid_d    = 1'b0;
      out_up_d   = '0;
      out_down_d = '0;
      out_rd_d   = '0;
    end else begin
      case (state_q)
        StReset: begin
          fix_d      = p_clk_count_fix_i;
          var_d      = p_clk_count_var_i;
          aper_cnt_d = p_clk_count_aper_i;
          up_d       = '0;
          down_d     = '0;
          rundown_d  = '0;
          enter_var  = 1'b1;
          var_len    = p_clk_count_var_i;
        end
        StVar: begin
          aper_cnt_d = aper_dec;
          if (phase_q == 16'd0) begin
            state_d  = StFix;
            phase_d  = fix_q - 16'd1;
            refmux_d = 2'b00;
          end else begin
            phase_d = phase_q - 16'd1;
          end
        end
        StFix: begin
          aper_cnt_d = aper_dec;
          if (phase_q != 16'd0) begin
            phase_d = phase_q - 16'd1;
          end else if (aper_dec == 24'd0) begin
            state_d  = StRundown;
            sigmux_d = 1'b0;
            dir_d    = comp_sync;
            refmux_d = ref_sel;
          end else begin
            enter_var = 1'b1;
          end
        end
        StRundown: begin
          // The crossing clock itself is not counted.
          if (comp_sync != dir_q) begin
            finish = 1'b1;
          end else begin
            rundown_d = rundown_q + 24'd1;
            if (rundown_d == RUNDOWN_MAX) begin
              ovf_d  = 1'b1;
              finish = 1'b1;
            end
          end
        end
        StDone: ;
        default: state_d = StReset;
      endcase

      if (enter_var) begin
        state_d  = StVar;
        sigmux_d = 1'b1;
        refmux_d = ref_sel;
        phase_d  = var_len - 16'd1;
        if (comp_sync) down_d = sat_inc(down_d);
        else           up_d   = sat_inc(up_d);
      end

      if (finish) begin
        state_d    = StDone;
        sigmux_d   = 1'b0;
        refmux_d   = 2'b00;
        valid_d    = 1'b1;
        out_up_d   = up_d;
        out_down_d = down_d;
        out_rd_d   = rundown_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StReset;
      fix_q      <= '0;
      var_q      <= '0;
      aper_cnt_q <= '0;
      phase_q    <= '0;
      up_q       <= '0;
      down_q     <= '0;
      rundown_q  <= '0;
      dir_q      <= 1'b0;
      ovf_q      <= 1'b0;
      sigmux_q   <= 1'b0;
      refmux_q   <= 2'b11;
      valid_q    <= 1'b0;
      out_up_q   <= '0;
      out_down_q <= '0;
      out_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      fix_q      <= fix_d;
      var_q      <= var_d;
      aper_cnt_q <= aper_cnt_d;
      phase_q    <= phase_d;
      up_q       <= up_d;
      down_q     <= down_d;
      rundown_q  <= rundown_d;
      dir_q      <= dir_d;
      ovf_q      <= ovf_d;
      sigmux_q   <= sigmux_d;
      refmux_q   <= refmux_d;
      valid_q    <= valid_d;
      out_up_q   <= out_up_d;
      out_down_q <= out_down_d;
      out_rd_q   <= out_rd_d;
    end
  end

  assign sigmux_o        = sigmux_q;
  assign refmux_o        = refmux_q;
  assign measure_valid_o = valid_q;
  assign count_up_o      = out_up_q;
  assign count_down_o    = out_down_q;
  assign count_rundown_o = out_rd_q;
  assign rundown_dir_o   = dir_q;
  assign overflow_o      = ovf_q;
  assign monitor_o       = {valid_q, adc_reset_ni, comp_sync, sigmux_q, refmux_q, state_q[1:0]};

endmodule

// File: tb/tb_adc_multislope_runup.sv
// Self-checking bench for adc_multislope_runup: table of conversions scored through a queue,
// plus hand sequences for reset, alternating run-up, abort and DONE hold.
module tb_adc_multislope_runup;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        adc_rst_n;
  logic [23:0] aper;
  logic [15:0] fix;
  logic [15:0] var_len;
  logic        comp;
  logic        sigmux;
  logic [1:0]  refmux;
  logic        valid;
  logic [23:0] cnt_up, cnt_down, cnt_rd;
  logic        dir, ovf;
  logic [7:0]  mon;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [23:0] aper;
    logic [15:0] fix;
    logic [15:0] var_len;
    logic        comp;
    int          flip;  // negedges after rundown entry before the comparator flips; <0 never
    logic [23:0] up;
    logic [23:0] down;
    logic [23:0] rd;
    logic        dir;
    logic        ovf;
  } vec_t;

  vec_t        vecs[5];
  vec_t        exp_q[$];
  logic [1:0]  ref_q[$];

  adc_multislope_runup #(
    .RUNDOWN_MAX(24'd1000),
    .SYNC_STAGES(S)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .adc_reset_ni      (adc_rst_n),
    .p_clk_count_aper_i(aper),
    .p_clk_count_fix_i (fix),
    .p_clk_count_var_i (var_len),
    .comparator_val_i  (comp),
    .sigmux_o          (sigmux),
    .refmux_o          (refmux),
    .measure_valid_o   (valid),
    .count_up_o        (cnt_up),
    .count_down_o      (cnt_down),
    .count_rundown_o   (cnt_rd),
    .rundown_dir_o     (dir),
    .overflow_o        (ovf),
    .monitor_o         (mon)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [1:0] st, input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (mon[1:0] == st) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      failures++;
      checks++;
      $display("FAIL wait_state_%0d timeout", st);
    end
  endtask

  task automatic wait_valid(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (valid) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      failures++;
      checks++;
      $display("FAIL wait_valid timeout");
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_refmux"}, 32'(refmux), 32'd3);
    chk({tag, "_sigmux"}, 32'(sigmux), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_up"}, 32'(cnt_up), 32'd0);
    chk({tag, "_down"}, 32'(cnt_down), 32'd0);
    chk({tag, "_rd"}, 32'(cnt_rd), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    chk({tag, "_dir"}, 32'(dir), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    bit   ok;
    vec_t e;
    adc_rst_n = 1'b0;
    aper      = v.aper;
    fix       = v.fix;
    var_len   = v.var_len;
    comp      = v.comp;
    repeat (4) @(negedge clk);
    exp_q.push_back(v);
    adc_rst_n = 1'b1;
    wait_state(2'b11, 5000, ok);
    if (ok) begin
      chk("rundown_refmux", 32'(refmux), v.dir ? 32'd2 : 32'd1);
      chk("rundown_sigmux", 32'(sigmux), 32'd0);
      chk("rundown_dir", 32'(dir), 32'(v.dir));
      if (v.flip >= 0) begin
        repeat (v.flip) @(negedge clk);
        comp = ~v.comp;
      end
    end
    wait_valid(3000, ok);
    e = exp_q.pop_front();
    if (ok) begin
      chk("done_up", 32'(cnt_up), 32'(e.up));
      chk("done_down", 32'(cnt_down), 32'(e.down));
      chk("done_rundown", 32'(cnt_rd), 32'(e.rd));
      chk("done_dir", 32'(dir), 32'(e.dir));
      chk("done_ovf", 32'(ovf), 32'(e.ovf));
      chk("done_refmux", 32'(refmux), 32'd0);
      chk("done_sigmux", 32'(sigmux), 32'd0);
    end
  endtask

  initial begin
    bit          ok;
    int          entries;
    logic [1:0]  prev_st;
    logic [1:0]  exp_ref;
    logic [31:0] r;

    vecs[0] = '{aper: 24'd100, fix: 16'd5, var_len: 16'd5, comp: 1'b1, flip: 30,
                up: 24'd0, down: 24'd10, rd: 24'(30 + S), dir: 1'b1, ovf: 1'b0};
    vecs[1] = '{aper: 24'd0, fix: 16'd3, var_len: 16'd4, comp: 1'b0, flip: 10,
                up: 24'd1, down: 24'd0, rd: 24'(10 + S), dir: 1'b0, ovf: 1'b0};
    vecs[2] = '{aper: 24'd23, fix: 16'd2, var_len: 16'd3, comp: 1'b0, flip: 5,
                up: 24'd5, down: 24'd0, rd: 24'(5 + S), dir: 1'b0, ovf: 1'b0};
    vecs[3] = '{aper: 24'd10, fix: 16'd1, var_len: 16'd1, comp: 1'b1, flip: 0,
                up: 24'd0, down: 24'd5, rd: 24'(0 + S), dir: 1'b1, ovf: 1'b0};
    vecs[4] = '{aper: 24'd20, fix: 16'd4, var_len: 16'd6, comp: 1'b1, flip: -1,
                up: 24'd0, down: 24'd2, rd: 24'd1000, dir: 1'b1, ovf: 1'b1};

    // Reset with the sequencer already requesting a conversion.
    reset_n   = 1'b0;
    adc_rst_n = 1'b1;
    aper      = 24'd0;
    fix       = 16'd1;
    var_len   = 16'd1;
    comp      = 1'b0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    reset_n = 1'b1;
    @(negedge clk);
    chk("release_state_var", 32'(mon[1:0]), 32'd1);
    chk("release_sigmux", 32'(sigmux), 32'd1);
    chk("release_refmux", 32'(refmux), 32'd1);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Last vector overflowed; hold DONE while inputs churn.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      comp = ~comp;
      r = $urandom;
      aper = r[23:0];
      fix = r[15:0] | 16'd1;
      var_len = r[31:16] | 16'd1;
      chk("hold_valid", 32'(valid), 32'd1);
      chk("hold_refmux", 32'(refmux), 32'd0);
      chk("hold_up", 32'(cnt_up), 32'd0);
      chk("hold_down", 32'(cnt_down), 32'd2);
      chk("hold_rd", 32'(cnt_rd), 32'd1000);
    end
    adc_rst_n = 1'b0;
    @(negedge clk);
    check_cleared("ovf_clear");

    // Alternating comparator at each VAR entry.
    aper    = 24'd40;
    fix     = 16'd2;
    var_len = 16'd2;
    comp    = 1'b1;
    repeat (4) @(negedge clk);
    ref_q.push_back(2'b10);
    adc_rst_n = 1'b1;
    entries = 0;
    prev_st = 2'b00;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mon[1:0] == 2'b01 && prev_st != 2'b01) begin
        entries++;
        if (ref_q.size() > 0) begin
          exp_ref = ref_q.pop_front();
          chk("alt_refmux", 32'(refmux), 32'(exp_ref));
        end
        if (entries < 10) begin
          comp = ~comp;
          ref_q.push_back(comp ? 2'b10 : 2'b01);
        end
      end
      prev_st = mon[1:0];
      if (prev_st == 2'b11) break;
    end
    chk("alt_entries", 32'(entries), 32'd10);
    chk("alt_queue_empty", 32'(ref_q.size()), 32'd0);
    comp = ~comp;
    wait_valid(200, ok);
    if (ok) begin
      chk("alt_up", 32'(cnt_up), 32'd5);
      chk("alt_down", 32'(cnt_down), 32'd5);
      chk("alt_dir", 32'(dir), 32'd0);
    end

    // Abort mid-VAR in the third run-up cycle, then a minimal conversion.
    adc_rst_n = 1'b0;
    aper      = 24'd100;
    fix       = 16'd5;
    var_len   = 16'd5;
    comp      = 1'b0;
    repeat (4) @(negedge clk);
    adc_rst_n = 1'b1;
    entries = 0;
    prev_st = 2'b00;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mon[1:0] == 2'b01 && prev_st != 2'b01) entries++;
      prev_st = mon[1:0];
      if (entries == 3) break;
    end
    chk("abort_reached_cycle3", 32'(entries), 32'd3);
    repeat (2) @(negedge clk);
    adc_rst_n = 1'b0;
    @(negedge clk);
    check_cleared("abort");
    chk("abort_state", 32'(mon[1:0]), 32'd0);
    aper    = 24'd0;
    fix     = 16'd3;
    var_len = 16'd3;
    comp    = 1'b1;
    repeat (3) @(negedge clk);
    adc_rst_n = 1'b1;
    wait_state(2'b11, 100, ok);
    comp = 1'b0;
    wait_valid(100, ok);
    if (ok) begin
      chk("aper0_sum", 32'(cnt_up) + 32'(cnt_down), 32'd1);
      chk("aper0_down", 32'(cnt_down), 32'd1);
      chk("aper0_rd", 32'(cnt_rd), 32'(S));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
